// File: rtl/egress_lane_serializer_if.sv
// ---------------------------------------------------------------------------
// egress_lane_serializer_if
//   Groups the handshake and status signals of the egress lane serializer.
//   The serializer accepts 64-bit words and emits them as four 16-bit beats.
//
//   Signals
//     in_data    [63:0]  word from the off-chip channel output stage
//     in_valid           in_data valid
//     in_ready           serializer can accept a word this cycle
//     out_data   [15:0]  current lane beat
//     out_valid          out_data valid
//     out_ready          downstream accepts the beat
//     out_last           current beat is lane 3 of its word
//     word_cnt   [7:0]   words fully emitted, modulo 256
//     fifo_level         occupied FIFO entries, 0..DEPTH
//
//   Modports
//     master  the serializer's own view (drives ready/out/status)
//     slave   the surrounding logic's view (drives in_*, out_ready)
// ---------------------------------------------------------------------------
interface egress_lane_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [7:0]       word_cnt;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, word_cnt, fifo_level
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, word_cnt, fifo_level
  );
endinterface

// File: rtl/egress_lane_serializer.sv
// ---------------------------------------------------------------------------
// egress_lane_serializer
//   Buffers 64-bit words in a DEPTH-entry FIFO and emits each one as four
//   16-bit beats, lane 0 (bits 15:0) first, one beat per cycle while the
//   downstream is ready. The head word is popped on the lane-3 handshake.
//
//   Ports
//     clk   clock, all state on the rising edge
//     rst   synchronous, active-high reset
//     bus   egress_lane_serializer_if.master (see interface for signals)
//
//   Parameter
//     DEPTH FIFO entries, power of two in 2..16
// ---------------------------------------------------------------------------
module egress_lane_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  egress_lane_serializer_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Storage is small, so it is read asynchronously: a word written in cycle N
  // must already drive lane 0 in cycle N+1.
  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [1:0]       r_beat;
  logic [7:0]       r_word_cnt;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_beat_hs;
  logic        w_pop;
  logic [63:0] w_head;
  logic [15:0] w_lane [4];

  // in_ready looks only at the registered level (never at out_ready), so a
  // full FIFO refuses a word even in the cycle its head is popped.
  assign w_in_ready  = !rst && (r_level < LVL_W'(DEPTH));
  // Level clears only at the reset edge, so gate with rst to keep the
  // outputs quiet during the whole reset cycle.
  assign w_out_valid = !rst && (r_level != '0);

  assign w_push    = bus.in_valid && w_in_ready;
  assign w_beat_hs = w_out_valid && bus.out_ready;
  assign w_pop     = w_beat_hs && (r_beat == 2'd3);

  assign w_head = r_mem[r_rd_ptr];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = w_head[16*gi +: 16];
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? w_lane[r_beat] : 16'h0000;
  assign bus.out_last   = w_out_valid && (r_beat == 2'd3);
  assign bus.word_cnt   = r_word_cnt;
  assign bus.fifo_level = r_level;

  // Storage has no reset; stale contents are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      // Beat index wraps 3 -> 0 naturally in two bits, which lines up with
      // the pop of the head word.
      if (w_beat_hs) begin
        r_beat <= r_beat + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_word_cnt <= r_word_cnt + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: tb/tb_egress_lane_serializer.sv
module tb_egress_lane_serializer;
  logic clk;
  logic rst;

  egress_lane_serializer_if #(.DEPTH(4)) bus ();

  egress_lane_serializer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] din;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_last;
    logic [7:0]  e_wc;
    logic [2:0]  e_lvl;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } beat_t;

  vec_t  tbl [$];
  int    n_vec = 0;
  int    n_err = 0;

  localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;

  function automatic logic [15:0] lane_of(int w, int k);
    return 16'hA000 + 16'(w * 256 + k);
  endfunction

  function automatic logic [63:0] fill_word(int w);
    return {lane_of(w, 3), lane_of(w, 2), lane_of(w, 1), lane_of(w, 0)};
  endfunction

  function automatic void add(logic r, logic iv, logic [63:0] d, logic ordy,
                              logic ir, logic ov, logic [15:0] od, logic last,
                              logic [7:0] wc, logic [2:0] lvl);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_last = last;
    v.e_wc = wc; v.e_lvl = lvl;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [63:0] d, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t q [$];
    int pushes;
    int cyc;
    logic iv;
    logic ordy;
    logic [63:0] d;

    drive(1'b1, 1'b0, 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // ---- vector table: reset, single word, backpressure, fill and drain ----
    add(1, 0, 64'h0, 0, 0, 0, 16'h0000, 0, 0, 0);
    // single word
    add(0, 1, W1,    1, 1, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 64'h0, 1, 1, 1, 16'h1111, 0, 0, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h2222, 0, 0, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h3333, 0, 0, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h4444, 1, 0, 1);
    add(0, 0, 64'h0, 1, 1, 0, 16'h0000, 0, 1, 0);
    // backpressure for 5 cycles on lane 1
    add(0, 1, W1,    1, 1, 0, 16'h0000, 0, 1, 0);
    add(0, 0, 64'h0, 1, 1, 1, 16'h1111, 0, 1, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 64'h0, 0, 1, 1, 16'h2222, 0, 1, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h2222, 0, 1, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h3333, 0, 1, 1);
    add(0, 0, 64'h0, 1, 1, 1, 16'h4444, 1, 1, 1);
    add(0, 0, 64'h0, 1, 1, 0, 16'h0000, 0, 2, 0);
    // fill with 5 words while stalled; 5th is refused
    add(0, 1, fill_word(0), 0, 1, 0, 16'h0000,   0, 2, 0);
    add(0, 1, fill_word(1), 0, 1, 1, lane_of(0, 0), 0, 2, 1);
    add(0, 1, fill_word(2), 0, 1, 1, lane_of(0, 0), 0, 2, 2);
    add(0, 1, fill_word(3), 0, 1, 1, lane_of(0, 0), 0, 2, 3);
    add(0, 1, fill_word(4), 0, 0, 1, lane_of(0, 0), 0, 2, 4);
    add(0, 1, fill_word(4), 0, 0, 1, lane_of(0, 0), 0, 2, 4);
    // drain: 16 beats in push order, no bubbles
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        add(0, 0, 64'h0, 1, (w == 0) ? 1'b0 : 1'b1, 1, lane_of(w, k), (k == 3),
            8'(2 + w), 3'(4 - w));
    add(0, 0, 64'h0, 1, 1, 0, 16'h0000, 0, 6, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i),   bus.in_ready,   tbl[i].e_ir);
      chk($sformatf("v%0d out_valid", i),  bus.out_valid,  tbl[i].e_ov);
      chk($sformatf("v%0d out_data", i),   bus.out_data,   tbl[i].e_od);
      chk($sformatf("v%0d out_last", i),   bus.out_last,   tbl[i].e_last);
      chk($sformatf("v%0d word_cnt", i),   bus.word_cnt,   tbl[i].e_wc);
      chk($sformatf("v%0d fifo_level", i), bus.fifo_level, tbl[i].e_lvl);
      tick();
    end

    // ---- full FIFO with pop in the same cycle: no push until next cycle ----
    for (int w = 0; w < 4; w++) begin
      drive(0, 1, fill_word(10 + w), 0);
      @(negedge clk);
      chk($sformatf("full fill%0d in_ready", w), bus.in_ready, 1'b1);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      drive(0, 1, fill_word(14), 1);
      @(negedge clk);
      chk($sformatf("full b%0d in_ready", b), bus.in_ready, 1'b0);
      chk($sformatf("full b%0d level", b), bus.fifo_level, 3'd4);
      chk($sformatf("full b%0d out_data", b), bus.out_data, lane_of(10, b));
      chk($sformatf("full b%0d out_last", b), bus.out_last, (b == 3));
      tick();
    end
    drive(0, 1, fill_word(14), 0);
    @(negedge clk);
    chk("full after pop level", bus.fifo_level, 3'd3);
    chk("full after pop in_ready", bus.in_ready, 1'b1);
    chk("full after pop out_data", bus.out_data, lane_of(11, 0));
    tick();
    drive(0, 0, 64'h0, 0);
    @(negedge clk);
    chk("full refill level", bus.fifo_level, 3'd4);
    chk("full refill in_ready", bus.in_ready, 1'b0);
    tick();

    // ---- reset, then 257 words through a scoreboard: word_cnt wraps to 1 ----
    drive(1, 0, 64'h0, 1);
    @(negedge clk);
    chk("rst in_ready", bus.in_ready, 1'b0);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_data", bus.out_data, 16'h0000);
    chk("rst out_last", bus.out_last, 1'b0);
    tick();
    tick();
    drive(0, 0, 64'h0, 0);
    @(negedge clk);
    chk("post rst level", bus.fifo_level, 3'd0);
    chk("post rst word_cnt", bus.word_cnt, 8'd0);
    chk("post rst out_valid", bus.out_valid, 1'b0);
    chk("post rst in_ready", bus.in_ready, 1'b1);
    tick();

    pushes = 0;
    cyc = 0;
    while ((pushes < 257 || q.size() != 0) && cyc < 6000) begin
      iv   = (pushes < 257);
      d    = {16'(pushes * 4 + 3), 16'(pushes * 4 + 2), 16'(pushes * 4 + 1), 16'(pushes * 4)};
      ordy = ((cyc % 7) != 3);
      drive(0, iv, d, ordy);
      @(negedge clk);
      chk($sformatf("wrap c%0d out_valid", cyc), bus.out_valid, (q.size() != 0));
      if (bus.out_valid && ordy && q.size() != 0) begin
        chk($sformatf("wrap c%0d out_data", cyc), bus.out_data, q[0].d);
        chk($sformatf("wrap c%0d out_last", cyc), bus.out_last, q[0].l);
        void'(q.pop_front());
      end
      if (iv && bus.in_ready) begin
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          b.d = d[16*k +: 16];
          b.l = (k == 3);
          q.push_back(b);
        end
        pushes++;
      end
      tick();
      cyc++;
    end
    chk("wrap completed within budget", (cyc < 6000), 1'b1);
    drive(0, 0, 64'h0, 0);
    @(negedge clk);
    chk("wrap word_cnt", bus.word_cnt, 8'd1);
    chk("wrap level", bus.fifo_level, 3'd0);
    tick();

    // ---- reset at beat 2 with 3 words buffered ----
    for (int w = 0; w < 3; w++) begin
      drive(0, 1, fill_word(20 + w), 0);
      tick();
    end
    drive(0, 0, 64'h0, 1);
    tick();
    tick();
    drive(0, 0, 64'h0, 0);
    @(negedge clk);
    chk("mid beat2 out_data", bus.out_data, lane_of(20, 2));
    chk("mid beat2 level", bus.fifo_level, 3'd3);
    tick();
    drive(1, 0, 64'h0, 1);
    @(negedge clk);
    chk("mid rst in_ready", bus.in_ready, 1'b0);
    chk("mid rst out_valid", bus.out_valid, 1'b0);
    chk("mid rst out_data", bus.out_data, 16'h0000);
    chk("mid rst out_last", bus.out_last, 1'b0);
    tick();
    drive(0, 1, fill_word(30), 1);
    @(negedge clk);
    chk("mid release level", bus.fifo_level, 3'd0);
    chk("mid release word_cnt", bus.word_cnt, 8'd0);
    chk("mid release out_valid", bus.out_valid, 1'b0);
    chk("mid release in_ready", bus.in_ready, 1'b1);
    tick();
    drive(0, 0, 64'h0, 0);
    @(negedge clk);
    chk("mid new word out_data", bus.out_data, lane_of(30, 0));
    chk("mid new word out_valid", bus.out_valid, 1'b1);
    chk("mid new word out_last", bus.out_last, 1'b0);
    chk("mid new word level", bus.fifo_level, 3'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/egress_lane_serializer.md
EGRESS_LANE_SERIALIZER -- requirements
Module: egress_lane_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 64-bit word entries in the input FIFO (power of two, 2..16).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have in_data  input  64  word from the off-chip channel output stage.
REQ-005 SHALL have in_valid  input  1  in_data valid.
REQ-006 SHALL have in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have out_data  output  16  current lane beat.
REQ-008 SHALL have out_valid  output  1  out_data valid.
REQ-009 SHALL have out_ready  input  1  downstream accepts beat.
REQ-010 SHALL have out_last  output  1  current beat is lane 3, the last beat of its word.
REQ-011 SHALL have word_cnt  output  8  count of words fully emitted, modulo 256.
REQ-012 SHALL have fifo_level  output  log2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-013 Push SHALL occur when in_valid && in_ready; the word is written at the write pointer, which then increments modulo DEPTH.
REQ-014 in_ready SHALL equal !rst && (fifo_level < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-015 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; the slot is offered the following cycle.
REQ-016 out_valid SHALL equal (fifo_level != 0).
REQ-017 A 2-bit beat index SHALL select out_data = head[16*beat+15 : 16*beat], lane 0 (bits 15:0) first.
REQ-018 out_data SHALL be 16'h0000 when out_valid is 0.
REQ-019 A beat handshake SHALL occur when out_valid && out_ready; beat increments by 1.
REQ-020 On the beat-3 handshake, beat SHALL wrap to 0, the head SHALL pop (read pointer +1 modulo DEPTH) and word_cnt SHALL increment, wrapping 255->0.
REQ-021 out_last SHALL equal out_valid && (beat == 3).
REQ-022 While out_valid && !out_ready, out_data, out_last and beat SHALL hold stable.
REQ-023 Latency: a word pushed in cycle N SHALL present lane 0 on out_data in cycle N+1, given the FIFO was empty.
REQ-024 Throughput SHALL be one beat per cycle while out_ready=1 and the FIFO is non-empty, with no bubble between consecutive words.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged; push alone +1; pop alone -1.
REQ-026 fifo_level SHALL never exceed DEPTH nor underflow below 0.
REQ-027 Pushes during beats 1..3 SHALL NOT alter the head word or the beat index.

Reset
REQ-028 While rst=1, the following SHALL be cleared at the clock edge: write/read pointers to 0, fifo_level 0, beat 0 and word_cnt 0.
REQ-029 While rst=1, the outputs SHALL be in_ready=0, out_valid=0, out_last=0 and out_data=0; FIFO storage is not cleared.
REQ-030 rst asserted mid-word SHALL discard all buffered words and the partial beat; the first cycle after rst deasserts SHALL have in_ready=1 and out_valid=0.

Verification
REQ-031 Single word: push 64'h4444_3333_2222_1111 with out_ready=1 -> cycles N+1..N+4 show 1111,2222,3333,4444; out_last only on 4444; word_cnt=1; fifo_level returns to 0.
REQ-032 Backpressure: out_ready=0 for 5 cycles after lane 1 is shown -> out_data holds 2222 and beat holds 1; emission resumes at 3333 with no beat lost or repeated.
REQ-033 Fill: out_ready=0 and push 5 words continuously -> in_ready drops after the 4th, fifo_level=4, and the 5th word is held by the source; with out_ready=1, 16 beats emerge in push order.
REQ-034 Full with pop: full FIFO, out_ready=1 at beat 3 with in_valid=1 -> no push that cycle; push next cycle; fifo_level 4->3->4.
REQ-035 Counter wrap: emit 257 words -> word_cnt reads 1.
REQ-036 Reset mid-word: rst at beat 2 with 3 words buffered -> after release fifo_level=0, word_cnt=0, out_valid=0; the next pushed word starts at lane 0.
